// File: rtl/dmem_port_arbiter.sv
// Two-way round-robin arbiter with bounded lock in front of the single data-memory port.
// Latency: grant and memory access are combinational (same cycle); read data returns one cycle after grant.
// Backpressure: a requester holds its access with i_req high until o_gnt[k]; an ungranted request simply waits.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   i_req/i_lock/i_wren [1:0]      per-requester access, ownership hold, write flag
//   i_addr/i_data/i_mask           per-requester fields, packed [k*W +: W]
//   o_gnt [1:0]                    one-hot or zero; granted access executes this cycle
//   o_rvalid [1:0], o_rdata        registered read response, o_rvalid bit selects the owner
//   o_mem_addr/data/mask/wren      memory port, zero when nothing is granted
//   i_mem_data                     memory read data, valid the same cycle as o_mem_addr
module dmem_port_arbiter #(
   parameter int ADDR_W    = 30,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              i_req,
   input  logic [1:0]              i_lock,
   input  logic [2*ADDR_W-1:0]     i_addr,
   input  logic [2*DATA_W-1:0]     i_data,
   input  logic [2*DATA_W/8-1:0]   i_mask,
   input  logic [1:0]              i_wren,
   output logic [1:0]              o_gnt,
   output logic [1:0]              o_rvalid,
   output logic [DATA_W-1:0]       o_rdata,
   output logic [ADDR_W-1:0]       o_mem_addr,
   output logic [DATA_W-1:0]       o_mem_data,
   output logic [DATA_W/8-1:0]     o_mem_mask,
   output logic                    o_mem_wren,
   input  logic [DATA_W-1:0]       i_mem_data
);

   localparam int MASK_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

   owner_t            owner_q, owner_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  burst_q, burst_d;
   logic [1:0]        gnt;
   logic              hold0, hold1, burst_ok;

   assign burst_ok = (burst_q < CNT_W'(MAX_BURST));

   always_comb begin
      gnt     = 2'b00;
      owner_d = IDLE;
      last_d  = last_q;
      burst_d = '0;

      // A lock only counts for the current owner, and only while it is still requesting.
      hold0 = (owner_q == OWN0) && i_req[0] && i_lock[0] && burst_ok;
      hold1 = (owner_q == OWN1) && i_req[1] && i_lock[1] && burst_ok;

      if (hold0)
         gnt = 2'b01;
      else if (hold1)
         gnt = 2'b10;
      else if (i_req[!last_q])
         gnt[!last_q] = 1'b1;
      else if (i_req[last_q])
         gnt[last_q] = 1'b1;

      // Nothing may reach memory while reset is held.
      if (rst)
         gnt = 2'b00;

      // A hold extends the burst; any round-robin grant (including a re-grant
      // after forced rotation found the other side idle) starts a fresh one.
      if (gnt[0]) begin
         last_d  = 1'b0;
         owner_d = i_lock[0] ? OWN0 : IDLE;
         burst_d = hold0 ? burst_q + CNT_W'(1) : CNT_W'(1);
      end else if (gnt[1]) begin
         last_d  = 1'b1;
         owner_d = i_lock[1] ? OWN1 : IDLE;
         burst_d = hold1 ? burst_q + CNT_W'(1) : CNT_W'(1);
      end
   end

   assign o_gnt = gnt;

   always_comb begin
      o_mem_addr = '0;
      o_mem_data = '0;
      o_mem_mask = '0;
      if (gnt[0]) begin
         o_mem_addr = i_addr[0 +: ADDR_W];
         o_mem_data = i_data[0 +: DATA_W];
         o_mem_mask = i_mask[0 +: MASK_W];
      end else if (gnt[1]) begin
         o_mem_addr = i_addr[ADDR_W +: ADDR_W];
         o_mem_data = i_data[DATA_W +: DATA_W];
         o_mem_mask = i_mask[MASK_W +: MASK_W];
      end
   end

   assign o_mem_wren = |(gnt & i_wren);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q  <= IDLE;
         last_q   <= 1'b1;          // requester 0 wins the first tie
         burst_q  <= '0;
         o_rvalid <= 2'b00;
         o_rdata  <= '0;
      end else begin
         owner_q  <= owner_d;
         last_q   <= last_d;
         burst_q  <= burst_d;
         o_rvalid <= gnt & ~i_wren;
         if (|(gnt & ~i_wren))
            o_rdata <= i_mem_data;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   i_req, i_lock, i_wren;
   logic [59:0]  i_addr;
   logic [63:0]  i_data;
   logic [7:0]   i_mask;
   logic [1:0]   o_gnt, o_rvalid;
   logic [31:0]  o_rdata;
   logic [29:0]  o_mem_addr;
   logic [31:0]  o_mem_data;
   logic [3:0]   o_mem_mask;
   logic         o_mem_wren;
   logic [31:0]  i_mem_data;

   logic [29:0]  a0, a1;
   logic [31:0]  d0, d1;
   logic [3:0]   m0, m1;

   assign i_addr = {a1, a0};
   assign i_data = {d1, d0};
   assign i_mask = {m1, m0};

   always #5 clk = ~clk;

   dmem_port_arbiter #(.ADDR_W(30), .DATA_W(32), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .i_req(i_req), .i_lock(i_lock), .i_addr(i_addr),
      .i_data(i_data), .i_mask(i_mask), .i_wren(i_wren), .o_gnt(o_gnt),
      .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_mem_addr(o_mem_addr),
      .o_mem_data(o_mem_data), .o_mem_mask(o_mem_mask), .o_mem_wren(o_mem_wren),
      .i_mem_data(i_mem_data)
   );

   // Environment memory driven by the DUT's memory port.
   logic [31:0] mem [0:63];
   assign i_mem_data = mem[o_mem_addr[5:0]];
   always @(posedge clk) begin
      if (o_mem_wren)
         for (int b = 0; b < 4; b++)
            if (o_mem_mask[b]) mem[o_mem_addr[5:0]][8*b +: 8] <= o_mem_data[8*b +: 8];
   end

   // Bench's own expectation of memory contents, updated from the accesses it expects.
   logic [31:0] ref_mem [0:63];

   typedef struct packed {
      logic [1:0]  rv;
      logic [31:0] dat;
   } resp_t;
   resp_t sb_q[$];

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One arbitration cycle: drive, check the same-cycle grant and memory port,
   // check last cycle's response, queue this cycle's expected response.
   task automatic step(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] wr,
                       input logic [1:0] exp_gnt, input string tag);
      logic [29:0] ea;
      logic [31:0] ed, cur;
      logic [3:0]  em;
      resp_t       e;
      i_req = req; i_lock = lock; i_wren = wr;
      @(negedge clk);
      ea = exp_gnt[0] ? a0 : (exp_gnt[1] ? a1 : 30'd0);
      ed = exp_gnt[0] ? d0 : (exp_gnt[1] ? d1 : 32'd0);
      em = exp_gnt[0] ? m0 : (exp_gnt[1] ? m1 : 4'd0);
      check({tag, "_gnt"}, o_gnt, exp_gnt);
      check({tag, "_maddr"}, o_mem_addr, ea);
      check({tag, "_mwren"}, o_mem_wren, |(exp_gnt & wr));
      check({tag, "_mmask"}, o_mem_mask, em);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, "_rvalid"}, o_rvalid, e.rv);
         if (e.rv != 2'b00) check({tag, "_rdata"}, o_rdata, e.dat);
      end else begin
         check({tag, "_rvalid_idle"}, o_rvalid, 2'b00);
      end
      cur = ref_mem[ea[5:0]];
      e.rv  = exp_gnt & ~wr;
      e.dat = cur;
      sb_q.push_back(e);
      if (|(exp_gnt & wr)) begin
         for (int b = 0; b < 4; b++)
            if (em[b]) cur[8*b +: 8] = ed[8*b +: 8];
         ref_mem[ea[5:0]] = cur;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i]     = 32'hA000_0000 | i;
         ref_mem[i] = 32'hA000_0000 | i;
      end
      mem[5]     = 32'h0;
      ref_mem[5] = 32'h0;
      a0 = 30'h10; a1 = 30'h20;
      d0 = 32'h1111_1111; d1 = 32'h2222_2222;
      m0 = 4'hF; m1 = 4'hF;
      rst = 1'b1; i_req = 2'b11; i_lock = 2'b11; i_wren = 2'b11;
      repeat (2) @(posedge clk);
      #1;
      // Reset state, with requests and writes presented while reset is high.
      check("rst_gnt", o_gnt, 2'b00);
      check("rst_rvalid", o_rvalid, 2'b00);
      check("rst_rdata", o_rdata, 32'h0);
      check("rst_mwren", o_mem_wren, 1'b0);
      check("rst_maddr", o_mem_addr, 30'h0);
      rst = 1'b0; i_lock = 2'b00; i_wren = 2'b00;

      // 1: simultaneous reads, req 0 wins the first tie.
      step(2'b11, 2'b00, 2'b00, 2'b01, "t1a");
      step(2'b10, 2'b00, 2'b00, 2'b10, "t1b");
      step(2'b00, 2'b00, 2'b00, 2'b00, "t1c");

      // 2: partial write from req 1, then read back the merged word.
      a1 = 30'h5; d1 = 32'hDEAD_BEEF; m1 = 4'b0011;
      step(2'b10, 2'b00, 2'b10, 2'b10, "t2w");
      m1 = 4'hF;
      step(2'b10, 2'b00, 2'b00, 2'b10, "t2r");
      step(2'b00, 2'b00, 2'b00, 2'b00, "t2d");
      check("t2_merge", o_rdata, 32'h0000_BEEF);
      a1 = 30'h20; d1 = 32'h2222_2222;

      // 3: req 0 locked, req 1 pending: four grants then forced rotation.
      for (int i = 0; i < 4; i++) step(2'b11, 2'b01, 2'b00, 2'b01, "t3hold");
      step(2'b11, 2'b01, 2'b00, 2'b10, "t3rot");
      step(2'b01, 2'b00, 2'b00, 2'b01, "t3back");
      step(2'b00, 2'b00, 2'b00, 2'b00, "t3d");

      // 4: lock released after two grants.
      step(2'b10, 2'b00, 2'b00, 2'b10, "t4pre");
      step(2'b11, 2'b01, 2'b00, 2'b01, "t4g1");
      step(2'b11, 2'b01, 2'b00, 2'b01, "t4g2");
      step(2'b11, 2'b00, 2'b00, 2'b10, "t4g3");
      step(2'b01, 2'b00, 2'b00, 2'b01, "t4g4");
      step(2'b00, 2'b00, 2'b00, 2'b00, "t4d");

      // 5: both requesting unlocked: strict alternation, no idle cycles.
      step(2'b10, 2'b00, 2'b00, 2'b10, "t5pre");
      for (int i = 0; i < 16; i++) begin
         a0 = 30'h10 + 30'(i); a1 = 30'h20 + 30'(i);
         step(2'b11, 2'b00, 2'b00, (i % 2 == 0) ? 2'b01 : 2'b10, "t5alt");
      end
      a0 = 30'h10; a1 = 30'h20;

      // 6: reset the cycle after a read grant.
      step(2'b01, 2'b00, 2'b00, 2'b01, "t6g");
      rst = 1'b1; i_req = 2'b11; i_wren = 2'b11;
      #1;
      check("t6_rvalid", o_rvalid, 2'b00);
      check("t6_gnt", o_gnt, 2'b00);
      check("t6_mwren", o_mem_wren, 1'b0);
      sb_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0; i_wren = 2'b00;
      check("t6_rdata_rst", o_rdata, 32'h0);
      step(2'b11, 2'b00, 2'b00, 2'b01, "t6tie");
      step(2'b00, 2'b00, 2'b00, 2'b00, "t6d");
      check("mem_5_final", mem[5], 32'h0000_BEEF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
